// File: rtl/fpu_arith_pkg.sv
// Shared definitions for the FPU arithmetic dispatcher: opcodes, flag/cc bit
// positions, the FP80 indefinite value and the response normalization helper.
package fpu_arith_pkg;

    typedef enum logic [3:0] {
        OP_ADD         = 4'd0,
        OP_SUB         = 4'd1,
        OP_MUL         = 4'd2,
        OP_DIV         = 4'd3,
        OP_SQRT        = 4'd4,
        OP_CMP         = 4'd5,
        OP_FP_TO_INT16 = 4'd6,
        OP_FP_TO_INT32 = 4'd7,
        OP_INT16_TO_FP = 4'd8,
        OP_INT32_TO_FP = 4'd9,
        OP_FP_TO_FP32  = 4'd10,
        OP_FP_TO_FP64  = 4'd11
    } fpu_op_e;

    localparam logic [3:0] OP_LAST = 4'd11;

    localparam int FLAG_INVALID     = 0;
    localparam int FLAG_DENORMAL    = 1;
    localparam int FLAG_ZERO_DIVIDE = 2;
    localparam int FLAG_OVERFLOW    = 3;
    localparam int FLAG_UNDERFLOW   = 4;
    localparam int FLAG_INEXACT     = 5;

    localparam int CC_LESS      = 0;
    localparam int CC_EQUAL     = 1;
    localparam int CC_GREATER   = 2;
    localparam int CC_UNORDERED = 3;

    localparam logic [79:0] FP80_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [5:0]  FLAGS_INVALID   = 6'(1) << FLAG_INVALID;
    localparam logic [3:0]  CC_UNORD_ONLY   = 4'(1) << CC_UNORDERED;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } disp_state_e;

    // Integer results are sign-extended, narrower FP encodings are zero-extended.
    function automatic logic [79:0] normalize_result(
        input logic [3:0]  op,
        input logic [79:0] fp80,
        input logic [15:0] i16,
        input logic [31:0] i32,
        input logic [31:0] f32,
        input logic [63:0] f64
    );
        logic [79:0] r;
        case (op)
            OP_FP_TO_INT16: r = {{64{i16[15]}}, i16};
            OP_FP_TO_INT32: r = {{48{i32[31]}}, i32};
            OP_FP_TO_FP32:  r = {48'd0, f32};
            OP_FP_TO_FP64:  r = {16'd0, f64};
            default:        r = fp80;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// Clearable WAIT-cycle counter; expired rises once TIMEOUT_CYCLES cycles would
// have been spent waiting, so the caller can leave WAIT on that same cycle.
module fpu_dispatch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    assign expired = (count_q >= LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 16'd0;
        end else if (count_en && !expired) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fpu_arith_dispatcher.sv
// Sequences one request at a time into the FPU arithmetic unit, captures and
// normalizes its reply, and keeps sticky exception flags and a hang watchdog.
module fpu_arith_dispatcher
    import fpu_arith_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [1:0]       req_rmode,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [79:0]      req_a,
    input  logic [79:0]      req_b,
    output logic [3:0]       au_operation,
    output logic             au_enable,
    output logic [1:0]       au_rounding_mode,
    output logic [79:0]      au_operand_a,
    output logic [79:0]      au_operand_b,
    output logic [15:0]      au_int16_in,
    output logic [31:0]      au_int32_in,
    output logic [31:0]      au_fp32_in,
    output logic [63:0]      au_fp64_in,
    input  logic             au_done,
    input  logic [79:0]      au_result,
    input  logic [15:0]      au_int16_out,
    input  logic [31:0]      au_int32_out,
    input  logic [31:0]      au_fp32_out,
    input  logic [63:0]      au_fp64_out,
    input  logic [3:0]       au_cc,
    input  logic [5:0]       au_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [79:0]      rsp_result,
    output logic [3:0]       rsp_cc,
    output logic [5:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic [5:0]       sticky_flags,
    input  logic             clear_sticky,
    output logic             busy
);

    disp_state_e      state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       rmode_q, rmode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [79:0]      a_q, a_d;
    logic [79:0]      b_q, b_d;
    logic [79:0]      result_q, result_d;
    logic [3:0]       cc_q, cc_d;
    logic [5:0]       flags_q, flags_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       sticky_q, sticky_d;

    logic wd_clear;
    logic wd_count;
    logic wd_expired;
    logic rsp_hs;

    fpu_dispatch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .count_en(wd_count),
        .expired (wd_expired)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign au_enable = (state_q == ST_ISSUE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_hs    = rsp_valid & rsp_ready;

    assign au_operation     = op_q;
    assign au_rounding_mode = rmode_q;
    assign au_operand_a     = a_q;
    assign au_operand_b     = b_q;
    assign au_int16_in      = a_q[15:0];
    assign au_int32_in      = a_q[31:0];
    assign au_fp32_in       = a_q[31:0];
    assign au_fp64_in       = a_q[63:0];

    assign rsp_tag      = tag_q;
    assign rsp_result   = result_q;
    assign rsp_cc       = cc_q;
    assign rsp_flags    = flags_q;
    assign rsp_timeout  = timeout_q;
    assign sticky_flags = sticky_q;

    // A handshake in the same cycle as a clear still lands in the sticky set.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sticky
            assign sticky_d[gi] = (sticky_q[gi] & ~clear_sticky) | (rsp_hs & flags_q[gi]);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rmode_d   = rmode_q;
        tag_d     = tag_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cc_d      = cc_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;
        wd_clear  = 1'b0;
        wd_count  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    rmode_d = req_rmode;
                    tag_d   = req_tag;
                    a_d     = req_a;
                    b_d     = req_b;
                    if (req_op > OP_LAST) begin
                        result_d  = FP80_INDEFINITE;
                        cc_d      = CC_UNORD_ONLY;
                        flags_d   = FLAGS_INVALID;
                        timeout_d = 1'b0;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (au_done) begin
                    result_d  = normalize_result(op_q, au_result, au_int16_out,
                                                 au_int32_out, au_fp32_out, au_fp64_out);
                    cc_d      = au_cc;
                    flags_d   = au_flags;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wd_expired) begin
                    result_d  = FP80_INDEFINITE;
                    cc_d      = CC_UNORD_ONLY;
                    flags_d   = FLAGS_INVALID;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wd_count = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rmode_q   <= '0;
            tag_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            cc_q      <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
            sticky_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rmode_q   <= rmode_d;
            tag_q     <= tag_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            cc_q      <= cc_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule

// File: tb/tb_fpu_arith_dispatcher.sv
// Scoreboard bench for fpu_arith_dispatcher: directed requests push expected
// responses; a monitor checks latency, stability and fields at each handshake.
module tb_fpu_arith_dispatcher;
    import fpu_arith_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_rmode;
    logic [3:0]  req_tag;
    logic [79:0] req_a, req_b;
    logic [3:0]  au_operation;
    logic        au_enable;
    logic [1:0]  au_rounding_mode;
    logic [79:0] au_operand_a, au_operand_b;
    logic [15:0] au_int16_in;
    logic [31:0] au_int32_in, au_fp32_in;
    logic [63:0] au_fp64_in;
    logic        au_done;
    logic [79:0] au_result;
    logic [15:0] au_int16_out;
    logic [31:0] au_int32_out, au_fp32_out;
    logic [63:0] au_fp64_out;
    logic [3:0]  au_cc;
    logic [5:0]  au_flags;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_tag;
    logic [79:0] rsp_result;
    logic [3:0]  rsp_cc;
    logic [5:0]  rsp_flags;
    logic        rsp_timeout;
    logic [5:0]  sticky_flags;
    logic        clear_sticky;
    logic        busy;

    fpu_arith_dispatcher #(.TIMEOUT_CYCLES(TO), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rmode(req_rmode), .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
        .au_operation(au_operation), .au_enable(au_enable),
        .au_rounding_mode(au_rounding_mode), .au_operand_a(au_operand_a),
        .au_operand_b(au_operand_b), .au_int16_in(au_int16_in),
        .au_int32_in(au_int32_in), .au_fp32_in(au_fp32_in), .au_fp64_in(au_fp64_in),
        .au_done(au_done), .au_result(au_result), .au_int16_out(au_int16_out),
        .au_int32_out(au_int32_out), .au_fp32_out(au_fp32_out),
        .au_fp64_out(au_fp64_out), .au_cc(au_cc), .au_flags(au_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_cc(rsp_cc), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout), .sticky_flags(sticky_flags),
        .clear_sticky(clear_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  tag;
        logic [79:0] res;
        logic [3:0]  cc;
        logic [5:0]  flags;
        logic        to;
        int          acc;
        int          lat;
        int          en;
        int          en_base;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   model_delay = 0;
    int   enable_count = 0;
    int   last_en_cyc = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Arithmetic unit model: pulses au_done model_delay cycles after au_enable (0 = never).
    initial begin
        au_done = 1'b0;
        forever begin
            @(negedge clk);
            if (au_enable) begin
                enable_count++;
                last_en_cyc = cyc;
                if (model_delay > 0) begin
                    repeat (model_delay) @(posedge clk);
                    #1 au_done = 1'b1;
                    @(posedge clk);
                    #1 au_done = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic        prev_v;
        logic [94:0] snap;
        exp_t        e;
        prev_v = 1'b0;
        snap   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_v = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
                    end else begin
                        check("rsp_latency", 128'(cyc - exp_q[0].acc), 128'(exp_q[0].lat));
                        snap = {rsp_tag, rsp_result, rsp_cc, rsp_flags, rsp_timeout};
                    end
                end else begin
                    check("rsp_stable", 128'({rsp_tag, rsp_result, rsp_cc, rsp_flags, rsp_timeout}), 128'(snap));
                end
                if (rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_tag", 128'(rsp_tag), 128'(e.tag));
                    check("rsp_result", 128'(rsp_result), 128'(e.res));
                    check("rsp_cc", 128'(rsp_cc), 128'(e.cc));
                    check("rsp_flags", 128'(rsp_flags), 128'(e.flags));
                    check("rsp_timeout", 128'(rsp_timeout), 128'(e.to));
                    check("au_enable_pulses", 128'(enable_count - e.en_base), 128'(e.en));
                    if (e.en != 0) check("au_enable_cycle", 128'(last_en_cyc - e.acc), 128'd1);
                    $display("[TB] rsp tag=%0d result=%h cc=%b flags=%b timeout=%0d cycle=%0d",
                             rsp_tag, rsp_result, rsp_cc, rsp_flags, rsp_timeout, cyc - e.acc);
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] rm, input logic [3:0] tag,
                        input logic [79:0] a, input logic [79:0] b,
                        input logic [79:0] eres, input logic [3:0] ecc,
                        input logic [5:0] efl, input logic eto, input int lat, input int en);
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < 100 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        check("req_ready_before_send", 128'(req_ready), 128'd1);
        req_valid = 1'b1; req_op = op; req_rmode = rm; req_tag = tag; req_a = a; req_b = b;
        e.tag = tag; e.res = eres; e.cc = ecc; e.flags = efl; e.to = eto;
        e.acc = cyc; e.lat = lat; e.en = en; e.en_base = enable_count;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_budget", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rmode = '0; req_tag = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1; clear_sticky = 1'b0;
        au_result = '0; au_int16_out = '0; au_int32_out = '0; au_fp32_out = '0;
        au_fp64_out = '0; au_cc = '0; au_flags = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 128'({req_ready, au_enable, rsp_valid, rsp_timeout, busy}), 128'(5'b10000));
        check("reset_data", 128'({rsp_result, sticky_flags}), 128'd0);
        reset_n = 1'b1;

        // MUL 2.0 x 3.0, done 5 cycles after the enable
        model_delay = 5; au_result = 80'h4001_C000_0000_0000_0000;
        send(OP_MUL, 2'b01, 4'd3, 80'h4000_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000,
             80'h4001_C000_0000_0000_0000, 4'b0000, 6'b000000, 1'b0, 7, 1);
        drain();
        check("au_operation_held", 128'(au_operation), 128'(OP_MUL));
        check("au_rmode_held", 128'(au_rounding_mode), 128'(2'b01));
        check("au_operand_b_held", 128'(au_operand_b), 128'(80'h4000_C000_0000_0000_0000));
        check("au_fp64_in_held", 128'(au_fp64_in), 128'(64'h8000_0000_0000_0000));

        // Conversions: sign/zero extension of the narrow results
        model_delay = 1; au_result = 80'h1234_5678_9ABC_DEF0_1111; au_int16_out = 16'hFFFE;
        send(OP_FP_TO_INT16, 2'b00, 4'd5, 80'h4000_8000_0000_0000_0000, '0,
             80'hFFFF_FFFF_FFFF_FFFF_FFFE, 4'b0000, 6'b000000, 1'b0, 3, 1);
        drain();
        au_int32_out = 32'h0001_2345;
        send(OP_FP_TO_INT32, 2'b00, 4'd6, '0, '0,
             80'h0000_0000_0000_0001_2345, 4'b0000, 6'b000000, 1'b0, 3, 1);
        drain();
        model_delay = 3; au_fp32_out = 32'h8040_0000;
        send(OP_FP_TO_FP32, 2'b10, 4'd7, '0, '0,
             80'h0000_0000_0000_8040_0000, 4'b0000, 6'b000000, 1'b0, 5, 1);
        drain();
        model_delay = 2; au_cc = 4'b0010; au_result = 80'h0;
        send(OP_CMP, 2'b00, 4'd8, 80'h3FFF_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000,
             80'h0, 4'b0010, 6'b000000, 1'b0, 4, 1);
        drain();
        au_cc = 4'b0000;
        check("sticky_clean", 128'(sticky_flags), 128'd0);

        // Illegal opcode 13: immediate INDEFINITE response, no enable
        send(4'd13, 2'b00, 4'd9, 80'h1, 80'h2, FP80_INDEFINITE, 4'b1000, 6'b000001, 1'b0, 1, 0);
        drain();
        check("sticky_after_illegal", 128'(sticky_flags), 128'(6'b000001));
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        check("sticky_cleared", 128'(sticky_flags), 128'd0);

        // Watchdog: unit never completes
        model_delay = 0;
        send(OP_SQRT, 2'b00, 4'd10, 80'h4000_8000_0000_0000_0000, '0,
             FP80_INDEFINITE, 4'b1000, 6'b000001, 1'b1, TO + 2, 1);
        drain();
        check("sticky_after_timeout", 128'(sticky_flags), 128'(6'b000001));

        // DIV with zero_divide, response back-pressured 4 cycles, clear in handshake cycle
        model_delay = 2; au_flags = 6'b000100; au_result = 80'h7FFF_8000_0000_0000_0000;
        rsp_ready = 1'b0;
        send(OP_DIV, 2'b00, 4'd11, 80'h3FFF_8000_0000_0000_0000, 80'h0,
             80'h7FFF_8000_0000_0000_0000, 4'b0000, 6'b000100, 1'b0, 4, 1);
        for (int i = 0; i < 50 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("div_rsp_seen", 128'(rsp_valid), 128'd1);
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1; clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        drain();
        check("sticky_clear_and_new", 128'(sticky_flags), 128'(6'b000100));
        au_flags = 6'b000000;

        // Reset while in WAIT aborts the operation
        model_delay = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_ADD; req_tag = 4'd12;
        req_a = 80'h4000_8000_0000_0000_0000; req_b = 80'h3FFF_8000_0000_0000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_in_wait", 128'(busy), 128'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_ctrl", 128'({req_ready, au_enable, rsp_valid, rsp_timeout, busy}), 128'(5'b10000));
        check("reset_mid_data", 128'({au_operand_a, sticky_flags}), 128'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        model_delay = 1; au_result = 80'h4000_C000_0000_0000_0000;
        send(OP_ADD, 2'b00, 4'd13, 80'h4000_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000,
             80'h4000_C000_0000_0000_0000, 4'b0000, 6'b000000, 1'b0, 3, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
